// File: rtl/ysyx_22041211_isram_axi.sv
// AXI4-Lite read-only instruction SRAM slave with range/alignment checks.
// Optional ISRAM_RAND_DELAY_EN adds an LFSR-driven random wait per fetch.
module ysyx_22041211_isram_axi #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] MEM_SIZE  = 32'h0800_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic                  pmem_ren_o,
  output logic [ADDR_WIDTH-1:0] pmem_raddr_o,
  input  logic [DATA_WIDTH-1:0] pmem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READ,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            err_q, err_d;
  logic [4:0]            cnt, delay;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rvalid_q;
  logic                  ar_hs;

  logic [ADDR_WIDTH:0] a_ext, lo_ext, hi_ext;

  assign arready_o = (state == IDLE) && rst;
  assign ar_hs     = arvalid_i && arready_o;

  // One extra bit so BASE_ADDR+MEM_SIZE never wraps to zero.
  assign a_ext  = {1'b0, araddr_i};
  assign lo_ext = {1'b0, BASE_ADDR};
  assign hi_ext = {1'b0, BASE_ADDR} + {1'b0, MEM_SIZE};

  always_comb begin
    err_d = 2'b00;
    if (a_ext < lo_ext || a_ext >= hi_ext)
      err_d = 2'b11;
    else if (araddr_i[1:0] != 2'b00)
      err_d = 2'b10;
  end

`ifdef ISRAM_RAND_DELAY_EN
  logic [3:0] lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      lfsr <= 4'b1001;
    else if (ar_hs)
      lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
  end

  assign delay = 5'(LATENCY) + {3'b000, lfsr[1:0]};
`else
  assign delay = 5'(LATENCY);
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (ar_hs) state_nxt = WAIT;
      WAIT: if (cnt == 5'd0) state_nxt = READ;
      READ: state_nxt = RESP;
      RESP: if (rready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      err_q    <= 2'b00;
      cnt      <= '0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (ar_hs) begin
            addr_q <= araddr_i;
            err_q  <= err_d;
            cnt    <= delay;
          end
        end
        WAIT: begin
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
        end
        READ: begin
          rdata_q  <= (err_q == 2'b00) ? pmem_rdata_i : '0;
          rresp_q  <= err_q;
          rvalid_q <= 1'b1;
        end
        RESP: begin
          if (rready_i) rvalid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign pmem_ren_o   = (state == READ) && (err_q == 2'b00);
  assign pmem_raddr_o = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign rdata_o      = rdata_q;
  assign rresp_o      = rresp_q;
  assign rvalid_o     = rvalid_q;

endmodule

// File: tb/tb_ysyx_22041211_isram_axi.sv
// Directed bench for ysyx_22041211_isram_axi: two instances, low and
// high memory windows, table-driven fetches plus reset/backpressure cases.
module tb_ysyx_22041211_isram_axi;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  logic [31:0] araddr     [2];
  logic        arvalid    [2];
  logic        arready    [2];
  logic [31:0] rdata      [2];
  logic [1:0]  rresp      [2];
  logic        rvalid     [2];
  logic        rready     [2];
  logic        pmem_ren   [2];
  logic [31:0] pmem_raddr [2];
  logic [31:0] pmem_rdata [2];

  int n_chk  = 0;
  int n_fail = 0;

  localparam int LAT0 = 1;
  localparam int LAT1 = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return a ^ 32'h1234_5678;
  endfunction

  assign pmem_rdata[0] = memf(pmem_raddr[0]);
  assign pmem_rdata[1] = memf(pmem_raddr[1]);

  ysyx_22041211_isram_axi #(
    .LATENCY(LAT0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .araddr_i(araddr[0]), .arvalid_i(arvalid[0]),
    .arready_o(arready[0]),
    .rdata_o(rdata[0]), .rresp_o(rresp[0]),
    .rvalid_o(rvalid[0]), .rready_i(rready[0]),
    .pmem_ren_o(pmem_ren[0]),
    .pmem_raddr_o(pmem_raddr[0]),
    .pmem_rdata_i(pmem_rdata[0])
  );

  ysyx_22041211_isram_axi #(
    .LATENCY(LAT1),
    .BASE_ADDR(32'hF800_0000),
    .MEM_SIZE(32'h0800_0000)
  ) dut1 (
    .clk(clk), .rst(rst),
    .araddr_i(araddr[1]), .arvalid_i(arvalid[1]),
    .arready_o(arready[1]),
    .rdata_o(rdata[1]), .rresp_o(rresp[1]),
    .rvalid_o(rvalid[1]), .rready_i(rready[1]),
    .pmem_ren_o(pmem_ren[1]),
    .pmem_raddr_o(pmem_raddr[1]),
    .pmem_rdata_i(pmem_rdata[1])
  );

  logic [3:0] lfsr_m [2];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input int d);
    int l;
    l = 2 + ((d == 0) ? LAT0 : LAT1);
`ifdef ISRAM_RAND_DELAY_EN
    l += int'(lfsr_m[d][1:0]);
    lfsr_m[d] = {lfsr_m[d][2:0], lfsr_m[d][3] ^ lfsr_m[d][2]};
`endif
    return l;
  endfunction

  task automatic fetch(input int d, input logic [31:0] a,
                       input logic [1:0] er, input int hold);
    int k;
    int rens;
    int el;
    logic [31:0] ed;
    logic [31:0] hd;
    logic [1:0]  hr;
    ed = (er == 2'b00) ? memf(a & ~32'h3) : 32'h0;
    @(negedge clk);
    araddr[d]  = a;
    arvalid[d] = 1'b1;
    rready[d]  = (hold == 0);
    chk("arready_idle", 32'(arready[d]), 32'h1);
    el = exp_lat(d);
    @(posedge clk);
    #1 arvalid[d] = 1'b0;
    k = 0;
    rens = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (pmem_ren[d]) begin
        rens++;
        chk("pmem_raddr", pmem_raddr[d], a & ~32'h3);
      end
    end while (!rvalid[d] && k < 20);
    if (!rvalid[d]) begin
      n_chk++;
      n_fail++;
      $display("FAIL rvalid_timeout: got none expected %0d", el);
      return;
    end
    chk("latency", 32'(k), 32'(el));
    chk("pmem_ren_cnt", 32'(rens), (er == 2'b00) ? 32'h1 : 32'h0);
    chk("rdata", rdata[d], ed);
    chk("rresp", 32'(rresp[d]), 32'(er));
    chk("arready_resp", 32'(arready[d]), 32'h0);
    hd = rdata[d];
    hr = rresp[d];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_rvalid", 32'(rvalid[d]), 32'h1);
      chk("hold_rdata", rdata[d], hd);
      chk("hold_rresp", 32'(rresp[d]), 32'(hr));
      chk("hold_arready", 32'(arready[d]), 32'h0);
    end
    rready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rvalid_drop", 32'(rvalid[d]), 32'h0);
    chk("arready_back", 32'(arready[d]), 32'h1);
    rready[d] = 1'b0;
  endtask

  typedef struct {
    int          d;
    logic [31:0] a;
    logic [1:0]  er;
    int          hold;
  } vec_t;

  vec_t vt[11];

  initial begin
    vt[0]  = '{0, 32'h8000_0000, 2'b00, 0};
    vt[1]  = '{0, 32'h8000_0002, 2'b10, 0};
    vt[2]  = '{0, 32'h7FFF_FFFC, 2'b11, 0};
    vt[3]  = '{0, 32'h8000_0010, 2'b00, 5};
    vt[4]  = '{0, 32'h87FF_FFFC, 2'b00, 0};
    vt[5]  = '{0, 32'h8800_0000, 2'b11, 0};
    vt[6]  = '{0, 32'h8800_0001, 2'b11, 0};
    vt[7]  = '{0, 32'h8000_0103, 2'b10, 2};
    vt[8]  = '{1, 32'hFFFF_FFFC, 2'b00, 0};
    vt[9]  = '{1, 32'hF7FF_FFFC, 2'b11, 0};
    vt[10] = '{1, 32'hF800_0003, 2'b10, 0};

    for (int i = 0; i < 2; i++) begin
      araddr[i]  = 32'h0;
      arvalid[i] = 1'b0;
      rready[i]  = 1'b0;
      lfsr_m[i]  = 4'b1001;
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      arvalid[i] = 1'b1;
      #1;
      chk("rst_arready", 32'(arready[i]), 32'h0);
      chk("rst_rvalid", 32'(rvalid[i]), 32'h0);
      chk("rst_rdata", rdata[i], 32'h0);
      chk("rst_rresp", 32'(rresp[i]), 32'h0);
      chk("rst_pmem_ren", 32'(pmem_ren[i]), 32'h0);
      arvalid[i] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;

    foreach (vt[i])
      fetch(vt[i].d, vt[i].a, vt[i].er, vt[i].hold);

    // Reset while the first request sits in WAIT.
    @(negedge clk);
    araddr[0]  = 32'h8000_0008;
    arvalid[0] = 1'b1;
    void'(exp_lat(0));
    @(posedge clk);
    #1 arvalid[0] = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("abort_rvalid", 32'(rvalid[0]), 32'h0);
    chk("abort_pmem_ren", 32'(pmem_ren[0]), 32'h0);
    chk("abort_arready", 32'(arready[0]), 32'h0);
    lfsr_m[0] = 4'b1001;
    lfsr_m[1] = 4'b1001;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_beat", 32'(rvalid[0]), 32'h0);
    end
    rst = 1'b1;
    fetch(0, 32'h8000_0004, 2'b00, 0);

    // Back-to-back fetches on the zero-latency high window.
    for (int i = 0; i < 16; i++)
      fetch(1, 32'hF800_0000 + 32'(i * 4), 2'b00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
